usreg_param: RTL and testbench
==============================

# usreg_param

Parametrised universal shift register, the next generation of the 4-bit universal shift register. Adds a generic width, rotate, arithmetic-shift and clear modes, separate serial inputs and outputs for each direction, and a counted burst engine. The burst engine applies one operation N times autonomously and signals completion with a busy/done handshake. It serves as a shared datapath primitive for serialisers, barrel-shift emulation and LFSR-style front ends.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the burst count port
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- en  in  1  enables a single direct operation this cycle
- mode  in  3  operation select (encoding under Operation)
- data_in  in  WIDTH  parallel load value
- serial_in_r  in  1  bit entering the MSB on a right shift
- serial_in_l  in  1  bit entering the LSB on a left shift
- start  in  1  request a burst of `count` operations using `mode`
- count  in  CNT_W  burst length (0 … 2^CNT_W−1)
- data_out  out  WIDTH  register contents
- serial_out_r  out  1  data_out[0], combinational
- serial_out_l  out  1  data_out[WIDTH-1], combinational
- busy  out  1  burst in progress, registered
- done  out  1  one-cycle pulse when a burst completes, registered

## Operation
Modes:
- 000 hold
- 001 SHR: {serial_in_r, q[W-1:1]}
- 010 SHL: {q[W-2:0], serial_in_l}
- 011 load data_in
- 100 ROR: {q[0], q[W-1:1]}
- 101 ROL: {q[W-2:0], q[W-1]}
- 110 ASR: {q[W-1], q[W-1:1]}
- 111 clear to 0

Control states:
- Two states, IDLE and RUN, plus a remaining-count register of width CNT_W.
- IDLE, start=1:
  - latch `mode` into mode_q and `count` into rem.
  - If count≠0, go to RUN. If count=0, stay in IDLE and set done=1 for the next cycle.
  - data_out is not modified on the accepting edge.
  - start has priority over en.
- IDLE, start=0, en=1: apply `mode` to the register once on this edge.
- IDLE, start=0, en=0: hold.
- RUN, every edge:
  - apply mode_q and decrement rem.
  - When rem goes from 1 to 0, return to IDLE and set done=1 for one cycle.
- RUN ignores en, start, mode, count and data_in changes. It still uses the live serial_in_r/serial_in_l and, for load, the live data_in.
- busy = (state==RUN).
- Reset (rst=0 at an edge), from any state including mid-burst:
  - data_out=0, busy=0, done=0, state=IDLE, rem=0, mode_q=000.
  - serial_out_r and serial_out_l follow data_out, so both read 0.
  - The interrupted burst produces no done pulse.

## Timing
- Direct op: start sampled 0, en sampled 1 at edge k → data_out updated after edge k (1-cycle latency).
- Burst: start accepted at edge k with count=N>0:
  - busy high during cycles following edges k … k+N−1.
  - data_out changes at edges k+1 … k+N.
  - done high exactly in the cycle after edge k+N; busy is low in that same cycle.
- Back-to-back bursts: start may be asserted in the done cycle and is accepted, so there is no dead cycle.
- count=0: done pulses in the cycle after acceptance; busy never asserts.
- start while busy: ignored, not queued.

## Test plan
- Reset/load (WIDTH=8): hold rst=0 for 2 cycles → data_out=00, busy=0, done=0. Then en=1, mode=011, data_in=A5 → data_out=A5 after one edge; serial_out_l=1, serial_out_r=1.
- Direct modes from A5, one edge each:
  - SHR with sin_r=0 → 52
  - SHL with sin_l=1 → A5 again
  - ROR → D2
  - ROL → A5
  - ASR → D2
  - clear → 00
  - hold keeps the value.
- Burst: load 81, start with mode=101 (ROL) and count=3 → busy for 3 cycles; data_out steps 03, 06, 0C; done pulses once as busy falls. An en pulse mid-burst has no effect.
- Edge counts:
  - count=0 → done next cycle, busy stays 0, data unchanged.
  - count=15 of SHR with sin_r=1, starting from 00 → FF, then done.
  - start asserted in the done cycle → second burst starts immediately.
- Reset mid-burst: start SHL with count=10, assert rst=0 after 4 shifts → data_out=00, busy=0, no done pulse. After reset releases, a new burst runs normally.

Source files
------------

// File: rtl/usreg_param.sv
// Parametrised universal shift register with a counted burst engine; direct ops and burst steps take effect on the next edge.
// No backpressure: start is accepted only in IDLE (dropped while busy); done pulses one cycle after the final burst step.
module usreg_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shifted;
  logic [2:0]       op_sel;
  logic             accept;
  logic             do_op;
  logic             last_step;
  logic             done_q;

  // start beats en in IDLE; the accepting edge itself leaves the register alone
  assign accept    = (state_q == IDLE) && start;
  assign do_op     = (state_q == RUN) || ((state_q == IDLE) && !start && en);
  assign last_step = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign op_sel    = (state_q == RUN) ? mode_q : mode;

  always_comb begin
    shifted = q;
    case (op_sel)
      3'b000:  shifted = q;
      3'b001:  shifted = {serial_in_r, q[WIDTH-1:1]};
      3'b010:  shifted = {q[WIDTH-2:0], serial_in_l};
      3'b011:  shifted = data_in;
      3'b100:  shifted = {q[0], q[WIDTH-1:1]};
      3'b101:  shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b110:  shifted = {q[WIDTH-1], q[WIDTH-1:1]};
      default: shifted = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= 3'b000;
      q       <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= (accept && (count == '0)) || last_step;
      if (accept) begin
        rem_q  <= count;
        mode_q <= mode;
      end else if (state_q == RUN) begin
        rem_q <= rem_q - CNT_W'(1);
      end
      if (do_op) begin
        q <= shifted;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start && (count != '0)) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_out     = q;
    serial_out_r = q[0];
    serial_out_l = q[WIDTH-1];
    busy         = (state_q == RUN);
    done         = done_q;
  end

endmodule

// File: tb/tb_usreg_param.sv
// Directed bench for usreg_param (WIDTH=8, CNT_W=4): reset, direct modes, bursts, edge counts, reset mid-burst.
module tb_usreg_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       serial_in_r;
  logic       serial_in_l;
  logic       start;
  logic [3:0] count;
  logic [7:0] data_out;
  logic       serial_out_r;
  logic       serial_out_l;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  usreg_param #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .serial_in_r(serial_in_r), .serial_in_l(serial_in_l),
    .start(start), .count(count), .data_out(data_out),
    .serial_out_r(serial_out_r), .serial_out_l(serial_out_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; mode = 3'b000; data_in = 8'h00;
    serial_in_r = 1'b0; serial_in_l = 1'b0; start = 1'b0; count = 4'd0;
    tick(); tick();
    tests++;
    if ({data_out, busy, done, serial_out_l, serial_out_r} !== {8'h00, 4'b0000}) begin
      fails++;
      $display("FAIL reset: data/busy/done/sol/sor got %h %b%b%b%b want 00 0000",
               data_out, busy, done, serial_out_l, serial_out_r);
    end
    rst = 1'b1;
  endtask

  task automatic test_load;
    en = 1'b1; mode = 3'b011; data_in = 8'hA5;
    tick();
    en = 1'b0;
    tests++;
    if ({data_out, serial_out_l, serial_out_r} !== {8'hA5, 2'b11}) begin
      fails++;
      $display("FAIL load: data/sol/sor got %h %b%b want a5 11", data_out, serial_out_l, serial_out_r);
    end
  endtask

  task automatic test_direct_modes;
    logic [2:0] modes [7] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b000, 3'b111};
    logic [7:0] exps  [7] = '{8'h52, 8'hA5, 8'hD2, 8'hA5, 8'hD2, 8'hD2, 8'h00};
    serial_in_r = 1'b0; serial_in_l = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; mode = modes[i];
      tick();
      tests++;
      if (data_out !== exps[i]) begin
        fails++;
        $display("FAIL direct mode %b: got %h want %h", modes[i], data_out, exps[i]);
      end
    end
    en = 1'b0; mode = 3'b000;
    tick();
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL en_low_hold: got %h want 00", data_out);
    end
  endtask

  task automatic test_burst;
    logic [7:0] exps [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
    en = 1'b1; mode = 3'b011; data_in = 8'h81;
    tick();
    en = 1'b0; start = 1'b1; mode = 3'b101; count = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0; mode = 3'b000; count = 4'd9;
      en = (i == 1); mode = (i == 1) ? 3'b111 : 3'b000;
      tests++;
      if ({data_out, busy, done} !== {exps[i], (i < 3), (i == 3)}) begin
        fails++;
        $display("FAIL burst_rol step %0d: data/busy/done got %h %b%b want %h %b%b",
                 i, data_out, busy, done, exps[i], (i < 3), (i == 3));
      end
    end
    en = 1'b0;
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'h0C, 2'b00}) begin
      fails++;
      $display("FAIL burst_done_pulse_width: got %h %b%b want 0c 00", data_out, busy, done);
    end
  endtask

  task automatic test_count_zero;
    start = 1'b1; mode = 3'b111; count = 4'd0;
    tick();
    start = 1'b0;
    tests++;
    if ({data_out, busy, done} !== {8'h0C, 2'b01}) begin
      fails++;
      $display("FAIL count_zero: data/busy/done got %h %b%b want 0c 01", data_out, busy, done);
    end
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'h0C, 2'b00}) begin
      fails++;
      $display("FAIL count_zero_after: got %h %b%b want 0c 00", data_out, busy, done);
    end
  endtask

  task automatic test_count_max;
    logic [7:0] exp;
    en = 1'b1; mode = 3'b111;
    tick();
    en = 1'b0; start = 1'b1; mode = 3'b001; count = 4'd15; serial_in_r = 1'b1;
    exp = 8'h00;
    tick();
    start = 1'b0;
    tests++;
    if ({data_out, busy, done} !== {8'h00, 2'b10}) begin
      fails++;
      $display("FAIL count_max_accept: got %h %b%b want 00 10", data_out, busy, done);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp = {1'b1, exp[7:1]};
      tests++;
      if ({data_out, busy, done} !== {exp, (i < 15), (i == 15)}) begin
        fails++;
        $display("FAIL count_max step %0d: got %h %b%b want %h %b%b",
                 i, data_out, busy, done, exp, (i < 15), (i == 15));
      end
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; mode = 3'b010; count = 4'd2; serial_in_l = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'hFE, 2'b10}) begin
      fails++;
      $display("FAIL b2b_first_step: got %h %b%b want fe 10", data_out, busy, done);
    end
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'hFC, 2'b01}) begin
      fails++;
      $display("FAIL b2b_first_done: got %h %b%b want fc 01", data_out, busy, done);
    end
    start = 1'b1; mode = 3'b100; count = 4'd1;
    tick();
    start = 1'b0;
    tests++;
    if ({data_out, busy, done} !== {8'hFC, 2'b10}) begin
      fails++;
      $display("FAIL b2b_second_accept: got %h %b%b want fc 10", data_out, busy, done);
    end
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'h7E, 2'b01}) begin
      fails++;
      $display("FAIL b2b_second_done: got %h %b%b want 7e 01", data_out, busy, done);
    end
  endtask

  task automatic test_reset_mid_burst;
    int done_seen;
    en = 1'b1; mode = 3'b111;
    tick();
    en = 1'b0; start = 1'b1; mode = 3'b010; count = 4'd10; serial_in_l = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({data_out, busy} !== {8'h0F, 1'b1}) begin
      fails++;
      $display("FAIL mid_burst_progress: got %h %b want 0f 1", data_out, busy);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({data_out, busy, done, serial_out_l, serial_out_r} !== {8'h00, 4'b0000}) begin
      fails++;
      $display("FAIL mid_burst_reset: got %h %b%b%b%b want 00 0000",
               data_out, busy, done, serial_out_l, serial_out_r);
    end
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy || (data_out != 8'h00)) done_seen++;
    end
    tests++;
    if (done_seen !== 0) begin
      fails++;
      $display("FAIL mid_burst_no_done: got %0d active cycles want 0", done_seen);
    end
    start = 1'b1; mode = 3'b001; count = 4'd2; serial_in_r = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'h80, 2'b10}) begin
      fails++;
      $display("FAIL post_reset_burst_step: got %h %b%b want 80 10", data_out, busy, done);
    end
    tick();
    tests++;
    if ({data_out, busy, done} !== {8'hC0, 2'b01}) begin
      fails++;
      $display("FAIL post_reset_burst_done: got %h %b%b want c0 01", data_out, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_direct_modes();
    test_burst();
    test_count_zero();
    test_count_max();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
